// File: rtl/dralm_if.sv
// Stream interface for the DRALM pipelined multiplier.
// Carries the input operand handshake (valid/ready, mode, x, y) and the
// output product handshake (valid/ready, p).
//   master : drives operands and out_ready_i, observes ready/valid/product
//   slave  : the multiplier side
interface dralm_if #(
    parameter int unsigned N = 16
) ();
    logic           in_valid_i;
    logic           in_ready_o;
    logic           in_signed_i;
    logic [N-1:0]   x_i;
    logic [N-1:0]   y_i;
    logic           out_valid_o;
    logic           out_ready_i;
    logic [2*N-1:0] p_o;

    modport master (
        output in_valid_i,
        output in_signed_i,
        output x_i,
        output y_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  p_o
    );

    modport slave (
        input  in_valid_i,
        input  in_signed_i,
        input  x_i,
        input  y_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output p_o
    );
endinterface

// File: rtl/dralm_pipe.sv
// Pipelined dynamic-range approximate logarithmic multiplier (DRALM).
// Three register stages: log conversion, log-domain add, antilog + sign.
// Whole pipe advances together when the output slot is free or being taken;
// bubbles are kept, so latency is exactly three advancing cycles.
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - asynchronous active-low reset
//   bus     - dralm_if slave: in_valid_i/in_ready_o/in_signed_i/x_i/y_i,
//             out_valid_o/out_ready_i/p_o (2N-bit approximate product)
module dralm_pipe #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 5
) (
    input logic    clk_i,
    input logic    rst_ni,
    dralm_if.slave bus
);
    localparam int unsigned LOGN = $clog2(N);
    localparam int unsigned OPW  = LOGN + W - 1;   // {k, frac}
    localparam int unsigned LW   = OPW + 1;        // compensated log sum
    localparam int unsigned KPW  = LW - (W - 1);   // product characteristic
    localparam int unsigned PW   = 2 * N;          // product width
    localparam int unsigned MW   = PW + W - 1;     // lossless antilog shift

    // Position of the most significant set bit; 0 for an all-zero input.
    function automatic logic [LOGN-1:0] lead_one(input logic [N-1:0] a);
        logic [LOGN-1:0] k;
        k = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (a[i]) k = LOGN'(i);
        end
        return k;
    endfunction

    logic en_c;

    logic           s1_valid_q;
    logic [OPW-1:0] s1_op_x_q;
    logic [OPW-1:0] s1_op_y_q;
    logic           s1_sign_q;
    logic           s1_zero_q;

    logic           s2_valid_q;
    logic [LW-1:0]  s2_l_q;
    logic           s2_sign_q;
    logic           s2_zero_q;

    logic           out_valid_q;
    logic [PW-1:0]  p_q;

    // Whole pipe moves when the output register is empty or being drained.
    assign en_c           = bus.out_ready_i | ~out_valid_q;
    assign bus.in_ready_o = en_c;
    assign bus.out_valid_o = out_valid_q;
    assign bus.p_o        = p_q;

    // Stage 1: ones-complement magnitude, leading-one, truncated mantissa.
    logic            s_x_c, s_y_c;
    logic [N-1:0]    abs_x_c, abs_y_c;
    logic [N-1:0]    nrm_x_c, nrm_y_c;
    logic [LOGN-1:0] k_x_c, k_y_c;
    logic [OPW-1:0]  op_x_c, op_y_c;
    logic            zero_c;

    always_comb begin
        s_x_c   = bus.in_signed_i & bus.x_i[N-1];
        s_y_c   = bus.in_signed_i & bus.y_i[N-1];
        abs_x_c = bus.x_i ^ {N{s_x_c}};
        abs_y_c = bus.y_i ^ {N{s_y_c}};
        k_x_c   = lead_one(abs_x_c);
        k_y_c   = lead_one(abs_y_c);
        // Normalise so the leading one sits at bit N-1; the next W-1 bits
        // are the mantissa fraction.
        nrm_x_c = abs_x_c << (LOGN'(N - 1) - k_x_c);
        nrm_y_c = abs_y_c << (LOGN'(N - 1) - k_y_c);
        op_x_c  = {k_x_c, nrm_x_c[N-2:N-W]};
        op_y_c  = {k_y_c, nrm_y_c[N-2:N-W]};
        zero_c  = (bus.x_i == '0) | (bus.y_i == '0);
    end

    // Stage 2: halved log sum plus one, LSB forced high for range compensation.
    logic [OPW-1:0] sum_c;
    logic [LW-1:0]  l_c;

    always_comb begin
        sum_c = OPW'(s1_op_x_q[OPW-1:1]) + OPW'(s1_op_y_q[OPW-1:1]) + OPW'(1);
        l_c   = {sum_c, 1'b1};
    end

    // Stage 3: antilog by shifting the restored mantissa, then apply sign.
    logic [KPW-1:0] kp_c;
    logic [W-1:0]   mp_c;
    logic [MW-1:0]  wide_c;
    logic [PW-1:0]  mag_c;
    logic [PW-1:0]  res_c;

    always_comb begin
        kp_c   = s2_l_q[LW-1:W-1];
        mp_c   = {1'b1, s2_l_q[W-2:0]};
        wide_c = MW'(mp_c) << kp_c;
        mag_c  = wide_c[MW-1:W-1];
        res_c  = s2_zero_q ? '0 : (mag_c ^ {PW{s2_sign_q}});
    end

    // Bits that are intentionally discarded by truncation.
    logic unused_bits;
    assign unused_bits = ^{nrm_x_c, nrm_y_c, wide_c, s1_op_x_q[0], s1_op_y_q[0]};

    // Pipeline registers: shift together on en_c, hold otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q  <= 1'b0;
            s1_op_x_q   <= '0;
            s1_op_y_q   <= '0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_l_q      <= '0;
            s2_sign_q   <= 1'b0;
            s2_zero_q   <= 1'b0;
            out_valid_q <= 1'b0;
            p_q         <= '0;
        end else if (en_c) begin
            s1_valid_q  <= bus.in_valid_i;
            s1_op_x_q   <= op_x_c;
            s1_op_y_q   <= op_y_c;
            s1_sign_q   <= s_x_c ^ s_y_c;
            s1_zero_q   <= zero_c;
            s2_valid_q  <= s1_valid_q;
            s2_l_q      <= l_c;
            s2_sign_q   <= s1_sign_q;
            s2_zero_q   <= s1_zero_q;
            out_valid_q <= s2_valid_q;
            p_q         <= res_c;
        end
    end
endmodule

// File: doc/dralm_pipe.md
Name: dralm_pipe

Overview:
- Pipelined, parametrised dynamic-range approximate logarithmic multiplier (DRALM).
- Operands are N bits wide and truncated to W-1 fraction bits. Each transaction selects signed or unsigned mode.
- Three register stages with a valid/ready stream interface at both ends. Drop-in arithmetic unit for accelerator datapaths that need throughput of one product per clock.

Parameters:
- N, 16, operand width in bits; must be at least 4 and a power of 2.
- W, 5, truncation width: the log mantissa keeps W-1 fraction bits; 2 <= W <= N.

Ports:
- clk_i  in  1  clock; all registers rise-edge triggered.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  input operands valid.
- in_ready_o  out  1  block accepts input this cycle.
- in_signed_i  in  1  1 = two's-complement operands, 0 = unsigned operands.
- x_i  in  N  operand x.
- y_i  in  N  operand y.
- out_valid_o  out  1  p_o holds a result.
- out_ready_i  in  1  downstream accepts p_o.
- p_o  out  2N  approximate product.

Behaviour:
- Reset (async assert, sync release): all stage valids = 0, out_valid_o = 0, p_o = 0, in_ready_o = 1.
- Advance enable: en = out_ready_i | ~out_valid_o. in_ready_o = en, purely combinational.
- When en = 1, all stages shift one step and stage1 captures in_valid_i with its operands. When en = 0, every register holds its value.
- Bubbles do not collapse. Latency is exactly 3 enabled cycles from input handshake to out_valid_o. Throughput is 1 per cycle.
- p_o and out_valid_o are registered outputs. p_o must stay stable while out_valid_o = 1 and out_ready_i = 0.

Stage 1 (per operand a):
- s = in_signed_i & a[N-1].
- abs = a ^ {N{s}}. This is a ones-complement approximation; do not add 1.
- k = index of the leading one of abs, or 0 if abs == 0.
- frac = (abs << (N-1-k))[N-2 : N-W], which is W-1 bits.
- op = {k, frac}, width log2(N)+W-1.
- Register sign = s_x ^ s_y and zero = (x_i == 0) | (y_i == 0).
- An all-ones signed operand gives abs = 0, hence op = 0, and is treated as magnitude 1, not zero.

Stage 2:
- S = (op_x >> 1) + (op_y >> 1) + 1, with one extra carry bit.
- L = {S, 1'b1}: the LSB is forced to 1 for dynamic-range compensation.
- Register L.

Stage 3:
- kp = L >> (W-1).
- mp = {1'b1, L[W-2:0]}.
- mag = (mp << kp) >> (W-1). Compute in a 2N+W-1 bit intermediate so no bits are lost, then take the low 2N bits.
- res = mag ^ {2N{sign}}.
- p_o = zero ? 0 : res.

Boundary and mode rules:
- Unsigned mode never produces a negative sign. The maximum operands fit in 2N bits.
- in_signed_i is sampled per transaction and travels with its data. Mixed-mode back-to-back traffic must be supported.
- Reset asserted mid-stream discards all in-flight results immediately. No partial output appears after release.

Test Plan:
- Signed, x=3, y=3, N=16, W=5 -> op=24 each, L=51 -> p_o = 0x00000009 exactly 3 cycles after accept.
- Signed, x=0xFFFD (-3), y=3 -> p_o = 0xFFFFFFF9 (-7). Also x=0, y=0x1234 -> p_o = 0. Also x=1, y=1 -> p_o = 1.
- Signed, x=y=0x7FFF -> kp=29, mp=31 -> p_o = 0x3E000000, with no overflow truncation.
- Unsigned, x=0xFFFF, y=2 -> p_o = 139264 (0x00022000). The same operands in signed mode give x treated as magnitude 1: p_o = ~mag(1*2) = 0xFFFFFFFD.
- Back-to-back stream of 5 ops with out_ready_i low for 4 cycles after the first result:
  - in_ready_o = 0 during the stall.
  - p_o is held stable.
  - All 5 results arrive in order with no loss or duplicate.
  - Alternate in_signed_i across the 5 ops to check per-transaction mode.
- Assert rst_ni low with 3 ops in flight -> out_valid_o = 0 and p_o = 0 immediately (asynchronous). No stale result appears after release.
